add_result_accumulator: RTL and testbench



---
 rtl/add_result_accumulator.sv | 169 ++++++++++++++++
 tb/tb_add_result_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_result_accumulator.sv
// -----------------------------------------------------------------------------
// add_result_accumulator
//
// Sits directly behind the 8-bit gate-level full adder. Each accepted adder
// result is widened to a 9-bit value {carry_in, sum_in} and added into an
// ACC_W-bit accumulator. After BURST_LEN samples, or on an early flush, the
// burst total is presented on a valid/ready port. The total is held until
// out_ready is seen. While it is held, in_ready is low, which stalls the
// adder's producer.
//
// Build option:
//   ACC_SATURATE_EN  - when defined, an overflowing add clamps the accumulator
//                      to 2^ACC_W-1. When undefined, the add wraps.
//                      out_ovf is set in both builds.
//
// Parameters:
//   BURST_LEN  samples per burst (1..255)
//   ACC_W      accumulator / out_data width (>= 9)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sum_in     8-bit sum from the adder
//   carry_in   carry-out of bit 7 from the adder
//   in_valid   sum_in/carry_in valid this cycle
//   in_ready   stage can accept a sample (low only while a result is held)
//   flush      close the current burst early
//   out_data   burst total
//   out_count  number of samples in the reported burst
//   out_ovf    the burst total exceeded 2^ACC_W-1
//   out_valid  out_data/out_count/out_ovf valid
//   out_ready  downstream takes the result
// -----------------------------------------------------------------------------
module add_result_accumulator #(
  parameter int BURST_LEN = 4,
  parameter int ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sum_in,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_data,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       count_q;
  logic             ovf_q;
  logic [ACC_W-1:0] out_data_q;
  logic [7:0]       out_count_q;
  logic             out_ovf_q;
  logic             out_valid_q;

  logic [ACC_W:0]   sample_v;
  logic [ACC_W:0]   sum_full;
  logic             add_carry;
  logic [7:0]       count_inc;
  logic             acc_en;
  logic             close_burst;
  logic [ACC_W-1:0] acc_d;
  logic [7:0]       count_d;
  logic             ovf_d;

  // The only difference between builds: what the accumulator keeps when the
  // add carries out of bit ACC_W-1. A clamped value stays clamped, because
  // any later non-zero add overflows again.
  function automatic logic [ACC_W-1:0] add_mux(input logic [ACC_W:0] s);
`ifdef ACC_SATURATE_EN
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
    return s[ACC_W-1:0];
`endif
  endfunction

  // in_ready depends on the registered state only. It has no path from
  // out_ready, so no sample can slip in on the cycle a result is consumed.
  assign in_ready = (state_q != HOLD);
  assign acc_en   = in_valid & in_ready;

  always_comb begin
    sample_v  = {{(ACC_W-8){1'b0}}, carry_in, sum_in};
    sum_full  = {1'b0, acc_q} + sample_v;
    add_carry = sum_full[ACC_W];
    count_inc = count_q + 8'd1;

    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (acc_en) begin
      acc_d   = add_mux(sum_full);
      count_d = count_inc;
      ovf_d   = ovf_q | add_carry;
    end

    // A flush with nothing stored and nothing arriving is ignored. A flush
    // that arrives with an accept includes that sample in the burst.
    close_burst = 1'b0;
    if (acc_en) begin
      close_burst = (count_inc == BURST_LEN_C) | flush;
    end else if (state_q != HOLD) begin
      close_burst = flush & (count_q != 8'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          acc_q   <= acc_d;
          count_q <= count_d;
          ovf_q   <= ovf_d;
          if (close_burst) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_d;
            out_count_q <= count_d;
            out_ovf_q   <= ovf_d;
          end else if (acc_en) begin
            state_q <= ACCUM;
          end
        end
        HOLD: begin
          // out_data_q keeps its value after consumption. It changes only
          // when the next result is loaded.
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_result_accumulator.sv
module tb_add_result_accumulator;

  // Three instances share one stimulus stream.
  //   inst 0: BURST_LEN=4, ACC_W=12 (defaults)
  //   inst 1: BURST_LEN=4, ACC_W=10 (reaches overflow)
  //   inst 2: BURST_LEN=1, ACC_W=12
  localparam int NI = 3;
  int BL[NI] = '{4, 4, 1};
  int AW[NI] = '{12, 10, 12};

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sum_in;
  logic        carry_in;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic [11:0] od0, od2;
  logic [9:0]  od1;
  logic [7:0]  oc0, oc1, oc2;
  logic        ov0, ov1, ov2;
  logic        vl0, vl1, vl2;
  logic        ir0, ir1, ir2;

  add_result_accumulator #(.BURST_LEN(4), .ACC_W(12)) dut0 (
    .clk(clk), .rst(rst), .sum_in(sum_in), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(ir0), .flush(flush),
    .out_data(od0), .out_count(oc0), .out_ovf(ov0), .out_valid(vl0),
    .out_ready(out_ready));

  add_result_accumulator #(.BURST_LEN(4), .ACC_W(10)) dut1 (
    .clk(clk), .rst(rst), .sum_in(sum_in), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(ir1), .flush(flush),
    .out_data(od1), .out_count(oc1), .out_ovf(ov1), .out_valid(vl1),
    .out_ready(out_ready));

  add_result_accumulator #(.BURST_LEN(1), .ACC_W(12)) dut2 (
    .clk(clk), .rst(rst), .sum_in(sum_in), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(ir2), .flush(flush),
    .out_data(od2), .out_count(oc2), .out_ovf(ov2), .out_valid(vl2),
    .out_ready(out_ready));

  always #5 clk = ~clk;

  logic [63:0] o_data[NI];
  logic [63:0] o_cnt[NI];
  logic        o_ovf[NI];
  logic        o_vld[NI];
  logic        o_rdy[NI];

  assign o_data[0] = 64'(od0);
  assign o_data[1] = 64'(od1);
  assign o_data[2] = 64'(od2);
  assign o_cnt[0]  = 64'(oc0);
  assign o_cnt[1]  = 64'(oc1);
  assign o_cnt[2]  = 64'(oc2);
  assign o_ovf[0]  = ov0;
  assign o_ovf[1]  = ov1;
  assign o_ovf[2]  = ov2;
  assign o_vld[0]  = vl0;
  assign o_vld[1]  = vl1;
  assign o_vld[2]  = vl2;
  assign o_rdy[0]  = ir0;
  assign o_rdy[1]  = ir1;
  assign o_rdy[2]  = ir2;

  int checks = 0;
  int errors = 0;

  // Reference model. It keeps the true (unbounded) sum of the burst and
  // derives the reported value from it arithmetically.
  int     m_cnt[NI];
  longint m_tot[NI];
  bit     m_hold[NI];
  longint e_data[NI];
  longint e_cnt[NI];
  bit     e_ovf[NI];
  bit     e_vld[NI];

  function automatic longint reduce(input longint t, input int aw);
    longint mx;
    mx = (longint'(1) << aw) - 1;
`ifdef ACC_SATURATE_EN
    return (t > mx) ? mx : t;
`else
    return t % (mx + 1);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_cnt[k]  = 0;
      m_tot[k]  = 0;
      m_hold[k] = 1'b0;
      e_data[k] = 0;
      e_cnt[k]  = 0;
      e_ovf[k]  = 1'b0;
      e_vld[k]  = 1'b0;
    end
  endtask

  // Applies the current inputs for one clock edge.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (m_hold[k]) begin
        if (out_ready) begin
          m_hold[k] = 1'b0;
          m_cnt[k]  = 0;
          m_tot[k]  = 0;
          e_vld[k]  = 1'b0;
        end
      end else begin
        if (in_valid) begin
          m_tot[k] += longint'({carry_in, sum_in});
          m_cnt[k]++;
        end
        if ((in_valid && m_cnt[k] == BL[k]) || (flush && m_cnt[k] >= 1)) begin
          m_hold[k] = 1'b1;
          e_vld[k]  = 1'b1;
          e_data[k] = reduce(m_tot[k], AW[k]);
          e_cnt[k]  = longint'(m_cnt[k]);
          e_ovf[k]  = (m_tot[k] > ((longint'(1) << AW[k]) - 1));
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.i%0d.valid", tag, k), 64'(o_vld[k]), 64'(e_vld[k]));
      chk($sformatf("%s.i%0d.data", tag, k), o_data[k], e_data[k]);
      chk($sformatf("%s.i%0d.count", tag, k), o_cnt[k], e_cnt[k]);
      chk($sformatf("%s.i%0d.ovf", tag, k), 64'(o_ovf[k]), 64'(e_ovf[k]));
      chk($sformatf("%s.i%0d.in_ready", tag, k), 64'(o_rdy[k]), 64'(!m_hold[k]));
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst       = 1'b1;
    sum_in    = '0;
    carry_in  = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Four full-scale samples with the stage stalled downstream.
    in_valid = 1'b1; sum_in = 8'hFF; carry_in = 1'b1;
    repeat (4) cycle("burst4");
    chk("plan.data0", 64'(od0), 64'h7FC);
    chk("plan.count0", 64'(oc0), 64'd4);
    chk("plan.ovf0", 64'(ov0), 64'd0);
    chk("plan.in_ready0", 64'(ir0), 64'd0);
`ifdef ACC_SATURATE_EN
    chk("plan.data1", 64'(od1), 64'h3FF);
`else
    chk("plan.data1", 64'(od1), 64'h3FC);
`endif
    chk("plan.ovf1", 64'(ov1), 64'd1);

    // Stall for five cycles with samples offered. None may be absorbed.
    repeat (5) cycle("stall");
    chk("stall.data0", 64'(od0), 64'h7FC);
    out_ready = 1'b1;
    cycle("consume");
    in_valid = 1'b0;
    chk("consume.valid0", 64'(vl0), 64'd0);
    chk("consume.in_ready0", 64'(ir0), 64'd1);
    out_ready = 1'b0;

    // Early flush that carries its own sample.
    in_valid = 1'b1; carry_in = 1'b0;
    sum_in = 8'h10; cycle("flush.a");
    sum_in = 8'h20; cycle("flush.b");
    sum_in = 8'h05; flush = 1'b1; cycle("flush.c");
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.data0", 64'(od0), 64'h35);
    chk("flush.count0", 64'(oc0), 64'd3);
    out_ready = 1'b1;
    cycle("flush.consume");
    cycle("flush.drain");

    // Flush while empty is ignored.
    flush = 1'b1;
    repeat (2) cycle("flush.empty");
    chk("flush.empty.valid0", 64'(vl0), 64'd0);
    flush = 1'b0;

    // Reset in the middle of a burst discards the partial burst.
    out_ready = 1'b0;
    in_valid = 1'b1; sum_in = 8'h7A; carry_in = 1'b1;
    repeat (2) cycle("pre_rst");
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("post_rst");
    out_ready = 1'b1;
    in_valid = 1'b1; sum_in = 8'h01; carry_in = 1'b0;
    repeat (4) cycle("after_rst");
    chk("after_rst.data0", 64'(od0), 64'd4);
    in_valid = 1'b0;
    repeat (2) cycle("after_rst.drain");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      sum_in    = 8'($urandom);
      carry_in  = 1'($urandom);
      cycle("rand");
    end

    // Drain, then run single-sample bursts at full rate.
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) cycle("drain");
    in_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      sum_in   = 8'($urandom);
      carry_in = 1'($urandom);
      cycle("bl1");
      if (e_vld[2]) chk("bl1.count2", 64'(oc2), 64'd1);
    end
    in_valid = 1'b0;
    cycle("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
